search_patch_server: RTL and testbench
======================================

Name: search_patch_server

Overview:
- Responder side of the correlation coordinate/reading interface.
- Captures one search patch (SEARCH_H_RES x SEARCH_V_RES pixels, raster order) from a pixel stream into on-chip RAM.
- Then answers (X,Y) coordinate requests from the correlation scorer with the stored pixel reading, one cycle later.
- Sits between the camera/pixel capture path and the correlation score engine; replaces ad-hoc combinational search-pixel lookup.

Parameters:
- SEARCH_H_RES, 32, patch width in pixels (valid X = 0..SEARCH_H_RES-1)
- SEARCH_V_RES, 32, patch height in pixels (valid Y = 0..SEARCH_V_RES-1)
- PIX_W, 10, pixel reading width
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= SEARCH_H_RES*SEARCH_V_RES

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST_N  in  1  asynchronous active-low reset
- iLoad  in  1  single-cycle pulse: start (or restart) patch capture
- iPix_valid  in  1  iPix carries a valid pixel this cycle
- iPix  in  PIX_W  incoming pixel, raster order, X fastest
- iRd_en  in  1  read request strobe, sampled with coordinates
- iX_search  in  13  requested X coordinate
- iY_search  in  13  requested Y coordinate
- oReading  out  PIX_W  pixel reading for the accepted request
- oReading_valid  out  1  oReading/oOut_of_range valid this cycle
- oOut_of_range  out  1  accepted request had X or Y outside the patch
- oReady  out  1  patch fully loaded; reads are served
- oBusy  out  1  capture in progress

Behaviour:
- Reset (iRST_N low, async): state IDLE; wr_ptr=0; oReading=0, oReading_valid=0, oOut_of_range=0, oReady=0, oBusy=0. RAM contents not cleared; they are unreadable until the next full load.
- FSM states IDLE, LOAD, READY.
  - IDLE: iLoad -> LOAD.
  - LOAD: iLoad -> restart LOAD with wr_ptr=0. Last pixel written (wr_ptr == H*V-1 with iPix_valid) -> READY.
  - READY: iLoad -> LOAD.
- Entering LOAD: wr_ptr=0, oBusy=1, oReady=0 from the cycle after iLoad.
- In LOAD, each cycle with iPix_valid=1: mem[wr_ptr] <= iPix, wr_ptr++. Gaps in iPix_valid are allowed. iPix_valid outside LOAD is ignored.
- Pixel count rule: exactly H*V accepted pixels complete the load. In the cycle after the last write, oBusy=0 and oReady=1. Extra pixels after completion are ignored.
- Reads:
  - Accepted only when state==READY and iRd_en=1.
  - Address = iY_search*SEARCH_H_RES + iX_search, computed at full width before truncation to ADDR_W.
  - Latency 1: oReading_valid=1 and oReading=mem[addr] in the next cycle.
  - Back-to-back reads are accepted every cycle (full throughput, no stall).
- Out of range (iX_search >= SEARCH_H_RES or iY_search >= SEARCH_V_RES): response has oReading_valid=1, oReading=0, oOut_of_range=1. No RAM aliasing.
- iRd_en while not READY: request dropped; oReading_valid=0 next cycle; oReading holds its previous value.
- oReading_valid and oOut_of_range are single-cycle per request. oReading holds its last value when no response is issued.
- iLoad and iRd_en in the same READY cycle: iLoad wins, the read is dropped (no valid response).
- A read accepted in the cycle before iLoad still returns its response on the following cycle.
- Reset mid-LOAD or mid-read: immediate return to IDLE; any pending response is cancelled.
- Read-during-write: cannot occur (reads only in READY, writes only in LOAD).

Test Plan:
- Reset then load 32x32 pixels with value = (Y*32+X) mod 1024, iPix_valid always high -> oBusy high for 1024 cycles; oReady=1 on the cycle after the 1024th pixel.
- After load, read (X=5,Y=3) -> next cycle oReading=101, oReading_valid=1, oOut_of_range=0. Read (31,31) -> 1023.
- Back-to-back reads (0,0),(1,0),(2,0) on consecutive cycles -> responses 0,1,2 on consecutive cycles.
- Read (32,0) and (0,40) -> oReading=0, oOut_of_range=1, oReading_valid=1 each.
- Load with iPix_valid toggling every other cycle; issue iLoad again after 500 pixels; then deliver 1024 pixels -> oReady only after the 1024th pixel of the second load, with contents from the second load. iRd_en during LOAD -> no oReading_valid.
- In READY, assert iLoad and iRd_en together -> no valid response, oReady drops next cycle. Assert iRST_N low mid-LOAD -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/search_patch_server.sv
// Search patch server: captures one raster-order patch into RAM, then answers
// (X,Y) coordinate reads with the stored pixel one cycle later.
module search_patch_server #(
  parameter int unsigned SEARCH_H_RES = 32,
  parameter int unsigned SEARCH_V_RES = 32,
  parameter int unsigned PIX_W        = 10,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iLoad,
  input  logic             iPix_valid,
  input  logic [PIX_W-1:0] iPix,
  input  logic             iRd_en,
  input  logic [12:0]      iX_search,
  input  logic [12:0]      iY_search,
  output logic [PIX_W-1:0] oReading,
  output logic             oReading_valid,
  output logic             oOut_of_range,
  output logic             oReady,
  output logic             oBusy
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} stateT;

  localparam int unsigned       TOTAL    = SEARCH_H_RES * SEARCH_V_RES;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(TOTAL - 1);

  stateT             state;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdAddr;
  logic              wrEn;
  logic              rdAccept;
  logic              rdOutOfRange;
  logic [PIX_W-1:0]  mem [2**ADDR_W];

  // A pixel arriving together with iLoad belongs to no load: the restart wins.
  assign wrEn         = (state == LOAD) && !iLoad && iPix_valid;
  assign rdAccept     = (state == READY) && iRd_en && !iLoad;
  assign rdOutOfRange = (32'(iX_search) >= SEARCH_H_RES) ||
                        (32'(iY_search) >= SEARCH_V_RES);
  assign rdAddr       = ADDR_W'(32'(iY_search) * SEARCH_H_RES + 32'(iX_search));

  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrPtr] <= iPix;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state          <= IDLE;
      wrPtr          <= '0;
      oReading       <= '0;
      oReading_valid <= 1'b0;
      oOut_of_range  <= 1'b0;
      oReady         <= 1'b0;
      oBusy          <= 1'b0;
    end else begin
      oReading_valid <= 1'b0;
      oOut_of_range  <= 1'b0;

      if (iLoad) begin
        state  <= LOAD;
        wrPtr  <= '0;
        oBusy  <= 1'b1;
        oReady <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (iPix_valid) begin
              if (wrPtr == LAST_PTR) begin
                state  <= READY;
                oBusy  <= 1'b0;
                oReady <= 1'b1;
              end else begin
                wrPtr <= wrPtr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      // Out-of-range requests are gated so they never alias onto a stored pixel.
      if (rdAccept) begin
        oReading_valid <= 1'b1;
        oOut_of_range  <= rdOutOfRange;
        oReading       <= rdOutOfRange ? '0 : mem[rdAddr];
      end
    end
  end

endmodule

// File: tb/tb_search_patch_server.sv
// Directed bench for search_patch_server: load, reads, range checks, restart,
// load/read collision and asynchronous reset.
module tb_search_patch_server;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iLoad;
  logic        iPix_valid;
  logic [9:0]  iPix;
  logic        iRd_en;
  logic [12:0] iX_search;
  logic [12:0] iY_search;
  logic [9:0]  oReading;
  logic        oReading_valid;
  logic        oOut_of_range;
  logic        oReady;
  logic        oBusy;

  int unsigned nChecks = 0;
  int unsigned nErrors = 0;

  search_patch_server #(
    .SEARCH_H_RES(32),
    .SEARCH_V_RES(32),
    .PIX_W(10),
    .ADDR_W(10)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iLoad(iLoad),
    .iPix_valid(iPix_valid),
    .iPix(iPix),
    .iRd_en(iRd_en),
    .iX_search(iX_search),
    .iY_search(iY_search),
    .oReading(oReading),
    .oReading_valid(oReading_valid),
    .oOut_of_range(oOut_of_range),
    .oReady(oReady),
    .oBusy(oBusy)
  );

  always #10 iCLK = ~iCLK;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Issue a single read, return with outputs showing its response.
  task automatic doRead(input int x, input int y);
    iRd_en    = 1'b1;
    iX_search = 13'(x);
    iY_search = 13'(y);
    step();
    iRd_en = 1'b0;
  endtask

  task automatic checkResp(input string tag, input int val, input bit oor);
    checkVal({tag, "_valid"}, 32'(oReading_valid), 32'd1);
    checkVal({tag, "_data"},  32'(oReading), 32'(val));
    checkVal({tag, "_oor"},   32'(oOut_of_range), 32'(oor));
  endtask

  task automatic pulseLoad();
    iLoad = 1'b1;
    iPix_valid = 1'b0;
    step();
    iLoad = 1'b0;
  endtask

  initial begin
    int busyCycles;
    int earlyReady;
    int rdLeak;

    iRST_N = 1'b0; iLoad = 1'b0; iPix_valid = 1'b0; iPix = '0;
    iRd_en = 1'b0; iX_search = '0; iY_search = '0;
    repeat (3) step();
    checkVal("rst_reading", 32'(oReading), 0);
    checkVal("rst_valid",   32'(oReading_valid), 0);
    checkVal("rst_oor",     32'(oOut_of_range), 0);
    checkVal("rst_ready",   32'(oReady), 0);
    checkVal("rst_busy",    32'(oBusy), 0);
    iRST_N = 1'b1;
    step();

    // Read in IDLE is dropped
    doRead(1, 1);
    checkVal("idle_rd_valid", 32'(oReading_valid), 0);

    // Full load, value = Y*32+X, valid every cycle
    pulseLoad();
    checkVal("load_busy", 32'(oBusy), 1);
    busyCycles = 0;
    earlyReady = 0;
    if (oBusy) busyCycles++;
    for (int i = 0; i < 1024; i++) begin
      iPix_valid = 1'b1;
      iPix = 10'(i);
      step();
      if (i < 1023) begin
        if (oBusy) busyCycles++;
        if (oReady) earlyReady++;
      end
    end
    iPix_valid = 1'b0;
    checkVal("load1_busy_cycles", 32'(busyCycles), 1024);
    checkVal("load1_early_ready", 32'(earlyReady), 0);
    checkVal("load1_ready", 32'(oReady), 1);
    checkVal("load1_busy_end", 32'(oBusy), 0);

    // Extra pixels after completion must not disturb contents
    iPix_valid = 1'b1; iPix = 10'h3AA; step(); iPix_valid = 1'b0;

    doRead(5, 3);   checkResp("rd_5_3", 101, 1'b0);
    doRead(31, 31); checkResp("rd_31_31", 1023, 1'b0);
    doRead(0, 0);   checkResp("rd_0_0", 0, 1'b0);

    // Back-to-back reads
    iRd_en = 1'b1; iY_search = '0;
    for (int i = 0; i < 3; i++) begin
      iX_search = 13'(i);
      step();
      checkVal("b2b_valid", 32'(oReading_valid), 1);
      checkVal("b2b_data",  32'(oReading), 32'(i));
    end
    iRd_en = 1'b0;
    step();
    checkVal("b2b_end_valid", 32'(oReading_valid), 0);
    checkVal("b2b_hold", 32'(oReading), 2);

    doRead(32, 0); checkResp("oor_x32", 0, 1'b1);
    doRead(7, 1);  checkResp("rd_7_1", 39, 1'b0);
    doRead(0, 40); checkResp("oor_y40", 0, 1'b1);
    step();
    checkVal("oor_single_cycle", 32'(oOut_of_range), 0);

    // Aborted load (500 pixels, toggling valid, reads during LOAD) then restart
    pulseLoad();
    checkVal("load2_ready_drop", 32'(oReady), 0);
    rdLeak = 0;
    iRd_en = 1'b1; iX_search = 13'd1; iY_search = 13'd0;
    for (int i = 0; i < 500; i++) begin
      iPix_valid = 1'b1; iPix = 10'h155; step();
      if (oReading_valid) rdLeak++;
      iPix_valid = 1'b0; step();
      if (oReading_valid) rdLeak++;
    end
    iRd_en = 1'b0;
    checkVal("load_rd_dropped", 32'(rdLeak), 0);
    pulseLoad();
    checkVal("restart_busy", 32'(oBusy), 1);
    earlyReady = 0;
    for (int i = 0; i < 1024; i++) begin
      iPix_valid = 1'b1; iPix = 10'(1023 - i); step();
      if (i < 1023 && oReady) earlyReady++;
      iPix_valid = 1'b0; step();
      if (i < 1023 && oReady) earlyReady++;
    end
    checkVal("load2_early_ready", 32'(earlyReady), 0);
    checkVal("load2_ready", 32'(oReady), 1);
    doRead(0, 0);   checkResp("l2_0_0", 1023, 1'b0);
    doRead(5, 3);   checkResp("l2_5_3", 922, 1'b0);
    doRead(31, 31); checkResp("l2_31_31", 0, 1'b0);

    // Read accepted just before iLoad still responds
    iRd_en = 1'b1; iX_search = 13'd2; iY_search = 13'd0; step();
    iRd_en = 1'b0; iLoad = 1'b1;
    checkResp("pre_load_rd", 1021, 1'b0);
    step();
    iLoad = 1'b0;
    checkVal("pre_load_ready", 32'(oReady), 0);
    for (int i = 0; i < 1024; i++) begin
      iPix_valid = 1'b1; iPix = 10'(i); step();
    end
    iPix_valid = 1'b0;
    checkVal("load3_ready", 32'(oReady), 1);

    // iLoad and iRd_en together in READY: load wins
    iLoad = 1'b1; iRd_en = 1'b1; iX_search = 13'd4; iY_search = 13'd4; step();
    iLoad = 1'b0; iRd_en = 1'b0;
    checkVal("collide_valid", 32'(oReading_valid), 0);
    checkVal("collide_ready", 32'(oReady), 0);
    checkVal("collide_busy",  32'(oBusy), 1);

    // Asynchronous reset mid-load
    for (int i = 0; i < 10; i++) begin
      iPix_valid = 1'b1; iPix = 10'(i); step();
    end
    iPix_valid = 1'b0;
    #4 iRST_N = 1'b0;
    #1;
    checkVal("arst_busy",    32'(oBusy), 0);
    checkVal("arst_ready",   32'(oReady), 0);
    checkVal("arst_reading", 32'(oReading), 0);
    checkVal("arst_valid",   32'(oReading_valid), 0);
    step();
    iRST_N = 1'b1;
    step();
    doRead(1, 1);
    checkVal("post_rst_rd_valid", 32'(oReading_valid), 0);
    checkVal("post_rst_busy", 32'(oBusy), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
